// File: rtl/la_ioshortctrl.sv
// rtl/la_ioshortctrl.sv - direction controller for a steerable bidirectional pad short
//
// Arbitrates side A and side B for one shared pad net. It inserts a high-Z
// turnaround gap of TURN cycles on every direction flip and drives the
// registered a2b select plus the per-side grants.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   req_a  - side A wants to drive (A->B), level
//   req_b  - side B wants to drive (B->A), level
//   a2b    - direction select, 1 = A drives B
//   oe     - short enable, 0 = both sides high-Z
//   gnt_a  - side A owns the net
//   gnt_b  - side B owns the net
//   busy   - controller is not idle
//
// Optional feature: define LA_IOSHORTCTRL_TIMEOUT_EN to build the MAXHOLD
// hold counter that lets a waiting side preempt a long-running owner.

module la_ioshortctrl #(
    parameter int unsigned TURN    = 2,
    parameter int unsigned MAXHOLD = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    output logic a2b,
    output logic oe,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy
);

    if (TURN < 1 || TURN > 255 || MAXHOLD < 1 || MAXHOLD > 65535) begin : g_bad_cfg
        $error("la_ioshortctrl: TURN or MAXHOLD out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_DRV_A, S_DRV_B} state_t;

    localparam logic [7:0] TURN_LOAD = 8'(TURN - 1);

    state_t     state_q, state_d;
    logic       a2b_q, a2b_d;
    logic       oe_q, oe_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       busy_q, busy_d;
    logic       last_q, last_d;     // 1 = A was granted most recently
    logic       pend_q, pend_d;     // side waiting out the turnaround, 1 = A
    logic [7:0] cnt_q, cnt_d;

`ifdef LA_IOSHORTCTRL_TIMEOUT_EN
    localparam logic [15:0] MAXHOLD_W = 16'(MAXHOLD);
    logic [15:0] hold_q, hold_d, hold_inc;
    logic        oth_req;
`endif

    logic win_a;        // idle arbitration result, 1 = A
    logic own_a;        // current owner in DRV, 1 = A
    logic own_req;
    logic pend_req;
    logic idle_go, turn_go, drv_go, dir_a;

    always_comb begin
        state_d = state_q;
        a2b_d   = a2b_q;
        oe_d    = oe_q;
        gnt_a_d = gnt_a_q;
        gnt_b_d = gnt_b_q;
        busy_d  = busy_q;
        last_d  = last_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        idle_go = 1'b0;
        turn_go = 1'b0;
        drv_go  = 1'b0;
        dir_a   = 1'b0;

        // Round-robin on a tie: the side that did not own the net last wins.
        win_a    = (req_a && req_b) ? ~last_q : req_a;
        own_a    = (state_q == S_DRV_A);
        own_req  = own_a ? req_a : req_b;
        pend_req = pend_q ? req_a : req_b;

`ifdef LA_IOSHORTCTRL_TIMEOUT_EN
        hold_d   = hold_q;
        hold_inc = (hold_q == MAXHOLD_W) ? hold_q : hold_q + 16'd1;
        oth_req  = own_a ? req_b : req_a;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    dir_a = win_a;
                    // No flip needed: the pad is already pointing the right way.
                    if (win_a == a2b_q) drv_go  = 1'b1;
                    else                turn_go = 1'b1;
                end
            end
            S_TURN: begin
                if (!pend_req) begin
                    idle_go = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    drv_go = 1'b1;
                    dir_a  = pend_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DRV_A, S_DRV_B: begin
                if (!own_req) begin
                    idle_go = 1'b1;
                end
`ifdef LA_IOSHORTCTRL_TIMEOUT_EN
                // hold_inc counts the DRV cycle ending now; preempt once the
                // owner has had MAXHOLD cycles and the other side is waiting.
                else if (hold_inc == MAXHOLD_W && oth_req) begin
                    turn_go = 1'b1;
                    dir_a   = ~own_a;
                end else begin
                    hold_d = hold_inc;
                end
`endif
            end
            default: idle_go = 1'b1;
        endcase

        if (idle_go) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            busy_d  = 1'b0;
        end
        if (turn_go) begin
            state_d = S_TURN;
            a2b_d   = dir_a;
            pend_d  = dir_a;
            cnt_d   = TURN_LOAD;
            oe_d    = 1'b0;
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            busy_d  = 1'b1;
        end
        if (drv_go) begin
            state_d = dir_a ? S_DRV_A : S_DRV_B;
            oe_d    = 1'b1;
            gnt_a_d = dir_a;
            gnt_b_d = ~dir_a;
            busy_d  = 1'b1;
            last_d  = dir_a;
`ifdef LA_IOSHORTCTRL_TIMEOUT_EN
            hold_d  = 16'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a2b_q   <= 1'b0;
            oe_q    <= 1'b0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= 8'd0;
`ifdef LA_IOSHORTCTRL_TIMEOUT_EN
            hold_q  <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            a2b_q   <= a2b_d;
            oe_q    <= oe_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
`ifdef LA_IOSHORTCTRL_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign a2b   = a2b_q;
    assign oe    = oe_q;
    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_la_ioshortctrl.sv
// tb/tb_la_ioshortctrl.sv - directed vector bench for la_ioshortctrl
module tb_la_ioshortctrl;

    logic clk = 1'b0;
    logic reset, req_a, req_b;
    logic a2b, oe, gnt_a, gnt_b, busy;

    int n_vec = 0;
    int n_err = 0;

    la_ioshortctrl #(.TURN(2), .MAXHOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req_a (req_a),
        .req_b (req_b),
        .a2b   (a2b),
        .oe    (oe),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // exp = {a2b, oe, gnt_a, gnt_b, busy} after the edge that samples the inputs
    typedef struct {
        logic       rst;
        logic       ra;
        logic       rb;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic a, input logic b, input logic [4:0] e);
        vec_t v;
        v.rst = r;
        v.ra  = a;
        v.rb  = b;
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {a2b, oe, gnt_a, gnt_b, busy};
    endfunction

    // One clock, then sample on the falling edge and check the invariants.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ((gnt_a && gnt_b) || (oe !== (gnt_a | gnt_b))) begin
            n_err++;
            $display("FAIL invariant: oe=%b gnt_a=%b gnt_b=%b expected one-hot grant matching oe",
                     oe, gnt_a, gnt_b);
        end
    endtask

    initial begin
        int n;

        add(1, 0, 0, 5'b00000);  // reset
        add(0, 0, 0, 5'b00000);
        add(0, 0, 1, 5'b01011);  // B, same direction: straight to DRV_B
        add(0, 0, 1, 5'b01011);
        add(0, 1, 1, 5'b01011);  // A alone cannot preempt
        add(0, 1, 0, 5'b00000);  // B releases
        add(0, 1, 0, 5'b10001);  // A: flip, TURN 1
        add(0, 1, 0, 5'b10001);  // TURN 2
        add(0, 1, 0, 5'b11101);  // DRV_A
        add(0, 1, 1, 5'b11101);
        add(0, 0, 1, 5'b10000);  // A releases
        add(0, 0, 1, 5'b00001);  // flip to B
        add(0, 0, 1, 5'b00001);
        add(0, 0, 1, 5'b01011);
        add(0, 0, 0, 5'b00000);
        add(0, 1, 0, 5'b10001);  // TURN toward A
        add(0, 0, 0, 5'b10000);  // A drops mid-TURN: IDLE, a2b kept
        add(0, 1, 0, 5'b11101);  // no flip needed now
        add(0, 0, 0, 5'b10000);
        add(0, 1, 0, 5'b11101);  // back-to-back same direction via IDLE
        add(0, 0, 0, 5'b10000);
        add(0, 1, 0, 5'b11101);
        add(1, 1, 0, 5'b00000);  // reset mid-DRV
        add(0, 1, 0, 5'b10001);
        add(0, 1, 0, 5'b10001);
        add(1, 1, 0, 5'b00000);  // reset during second TURN cycle
        add(0, 1, 0, 5'b10001);  // restart from IDLE
        add(0, 1, 0, 5'b10001);
        add(0, 1, 0, 5'b11101);
        add(1, 1, 1, 5'b00000);
        add(0, 1, 1, 5'b10001);  // first tie after reset goes to A
        add(0, 1, 1, 5'b10001);
        add(0, 1, 1, 5'b11101);
        add(0, 0, 1, 5'b10000);  // one IDLE cycle
        add(0, 0, 1, 5'b00001);  // two TURN cycles
        add(0, 0, 1, 5'b00001);
        add(0, 0, 1, 5'b01011);
        add(0, 0, 0, 5'b00000);
        add(0, 1, 0, 5'b10001);
        add(0, 1, 0, 5'b10001);
        add(0, 1, 0, 5'b11101);
        add(0, 0, 0, 5'b10000);
        add(0, 1, 1, 5'b00001);  // tie with last = A goes to B
        add(0, 1, 1, 5'b00001);
        add(0, 1, 1, 5'b01011);
        add(0, 0, 0, 5'b00000);

        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            req_a = tbl[i].ra;
            req_b = tbl[i].rb;
            step();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Long hold by A while B waits (last = B, so the tie goes to A).
        reset = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        chk("hold_turn1", 32'(outs()), 32'(5'b10001));
        step();
        chk("hold_turn2", 32'(outs()), 32'(5'b10001));
        step();
        chk("hold_drv_a", 32'(outs()), 32'(5'b11101));
        n = 1;
        for (int k = 0; k < 39; k++) begin
            step();
            if (!gnt_a) break;
            n++;
        end
`ifdef LA_IOSHORTCTRL_TIMEOUT_EN
        chk("hold_len", 32'(n), 32'd4);
        chk("preempt_turn1", 32'(outs()), 32'(5'b00001));
        step();
        chk("preempt_turn2", 32'(outs()), 32'(5'b00001));
        step();
        chk("preempt_drv_b", 32'(outs()), 32'(5'b01011));
`else
        chk("hold_len", 32'(n), 32'd40);
        chk("hold_still_a", 32'(outs()), 32'(5'b11101));
`endif
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        chk("final_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/la_ioshortctrl.md
# la_ioshortctrl

Direction controller for a bidirectional pad short (the `a`/`b` inout alias with `a2b` steering). It arbitrates between two requesters, side A and side B, that each want to drive the shared net. It inserts a programmable high-Z turnaround gap on every direction change and produces the registered `a2b` select plus per-side grants. It sits in the padring next to each steerable short and is the only legal driver of that short's `a2b` input.

## Interface
Parameters:
- `TURN`, default 2: turnaround cycles with both sides released when the direction flips; legal range 1..255.
- `MAXHOLD`, default 64: hold-timeout limit in cycles, used only when timeout is compiled in; legal range 1..65535.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req_a`  input  1  side A requests to drive (A→B); level, held until done.
- `req_b`  input  1  side B requests to drive (B→A); level, held until done.
- `a2b`  output  1  direction select to the short; 1 = A drives B, 0 = B drives A.
- `oe`  output  1  short enable; 0 = both sides must stay high-Z.
- `gnt_a`  output  1  side A owns the net.
- `gnt_b`  output  1  side B owns the net.
- `busy`  output  1  FSM is not in IDLE.

## Operation
- Four states: IDLE, TURN, DRV_A, DRV_B. All outputs are registered and decoded from state.
- Reset values: state = IDLE, `a2b` = 0, `oe` = 0, `gnt_a` = `gnt_b` = 0, `busy` = 0, `last` = B, counters = 0.
- Reset has priority over every other event, including reset asserted mid-TURN or mid-DRV; the next cycle shows reset values.
- `last` records the most recently granted side.
- IDLE:
  - Only one request: winner is that side.
  - Both requests: winner is the side not equal to `last` (round-robin; the first tie after reset goes to A).
  - If the winner's direction equals the current `a2b`, go straight to DRV_x.
  - Otherwise load the turnaround counter with `TURN`-1, set `a2b` to the new direction, and go to TURN with `oe` = 0.
- TURN:
  - `oe` = 0, no grants.
  - When the counter reaches 0, go to DRV of the pending winner.
  - If the pending winner drops its request during TURN, return to IDLE. `a2b` keeps its new value.
- DRV_A / DRV_B:
  - `oe` = 1, `a2b` fixed, and only the owning grant is high.
  - On entry, update `last`.
  - When the owner's request is low, go to IDLE.
  - A request from the other side alone never preempts, unless timeout is enabled.
- Invariants (must hold every cycle):
  - `gnt_a` and `gnt_b` are never both 1.
  - `oe` = 1 only in DRV states.
  - `a2b` changes only on entry to TURN, or in IDLE when no direction change is needed (no change in that case).

## Timing
- Same-direction grant: `req` sampled high at edge N → grant high after edge N+1 (1-cycle latency).
- Direction change from IDLE: grant high after edge N+1+`TURN`.
- Release: `req` sampled low at edge N → grant and `oe` low after edge N+1. A new opposite-direction grant follows no earlier than `TURN` further cycles, so `oe` is low for at least `TURN` cycles between opposite owners.
- Back-to-back same-direction grants pass through IDLE, which costs at least one cycle of `oe` = 0.

## Configuration
- `LA_IOSHORTCTRL_TIMEOUT_EN` defined:
  - A 16-bit hold counter clears on DRV entry and increments each DRV cycle, saturating at `MAXHOLD`.
  - When it equals `MAXHOLD` and the other side is requesting, the owner is preempted: go to TURN toward the other side. `last` updates on that DRV entry.
- Not defined:
  - No hold counter is built.
  - DRV is held for as long as the owner requests, with no preemption.
  - `MAXHOLD` is ignored.

## Test plan
- Reset, then `req_b`=1 at cycle 3 → `gnt_b`=1, `oe`=1, `a2b`=0 from cycle 4; no TURN is entered.
- `req_a` alone from reset with `TURN`=2 → `a2b`=1 after cycle 1, `oe`=0 for cycles 1–2, `gnt_a`=1 from cycle 3.
- `req_a`=`req_b`=1 from IDLE after reset → A is granted first. Drop `req_a` → B is granted after exactly 1 IDLE cycle plus 2 TURN cycles, with `gnt_a`/`gnt_b` never overlapping.
- Assert `reset` during the second TURN cycle → next cycle all outputs are 0 and state is IDLE; with `req_a` held, the sequence restarts from IDLE.
- With `LA_IOSHORTCTRL_TIMEOUT_EN` and `MAXHOLD`=4, A holds and B requests → A is preempted after 4 DRV cycles and B is granted `TURN` cycles later. Without the macro, A holds indefinitely.
